// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared types and constants for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C_DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : Operand and result valid/ready channels of the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_cell
// Brief    : One-bit combinational full adder.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_s,
    output logic      o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, valid/ready in and out.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
)(
    input  wire logic      clk,
    input  wire logic      rst_n,
    serial_adder_if.slave  bus
);
    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic [WIDTH:0]   w_sum_cat;
    logic             w_accept;
    logic             w_last;

    full_adder_cell u_fa (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // Slicing the concatenation keeps the MSB-side insert legal at WIDTH=1.
    assign w_sum_cat = {w_s, r_sum};
    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_last    = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = RUN;
            RUN:     if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sh_a  <= bus.a;
            r_sh_b  <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sh_a  <= r_sh_a >> 1;
            r_sh_b  <= r_sh_b >> 1;
            r_sum   <= w_sum_cat[WIDTH:1];
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) r_cout <= w_c;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one operand set to the 8-bit DUT and waits for its result.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat, output logic [7:0] s, output logic c);
        int g;
        g = 0;
        while (!if8.in_ready && g < 50) begin @(negedge clk); g++; end
        if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 100) begin @(negedge clk); lat++; end
        s = if8.sum;
        c = if8.cout;
    endtask

    task automatic release8;
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_w8: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.cout);
        end
        n_tests++;
        if ({if1.in_ready, if1.out_valid, if1.sum, if1.cout} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_w1: got rdy=%b vld=%b sum=%b cout=%b, want 1 0 0 0",
                     if1.in_ready, if1.out_valid, if1.sum, if1.cout);
        end
    endtask

    task automatic test_basic;
        int lat; logic [7:0] s; logic c;
        do_op8(8'h0F, 8'h01, 1'b0, lat, s, c);
        n_tests++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL latency: got %0d cycles, want 8", lat);
        end
        n_tests++;
        if ({c, s} !== 9'h010) begin
            n_fail++; $display("FAIL basic_sum: got cout=%b sum=%h, want 0 10", c, s);
        end
        release8();
        n_tests++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b, want 1 0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_overflow;
        int lat; logic [7:0] s; logic c;
        do_op8(8'hFF, 8'h01, 1'b0, lat, s, c);
        n_tests++;
        if ({c, s} !== 9'h100) begin
            n_fail++; $display("FAIL wrap_sum: got cout=%b sum=%h, want 1 00", c, s);
        end
        release8();
        do_op8(8'hFF, 8'hFF, 1'b1, lat, s, c);
        n_tests++;
        if ({c, s} !== 9'h1FF) begin
            n_fail++; $display("FAIL max_sum: got cout=%b sum=%h, want 1 ff", c, s);
        end
        release8();
    endtask

    task automatic test_backpressure;
        int lat; logic [7:0] s; logic c;
        do_op8(8'h5A, 8'hA5, 1'b0, lat, s, c);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                if8.a = 8'h01; if8.b = 8'h00; if8.cin = 1'b0; if8.in_valid = 1'b1;
            end else begin
                if8.in_valid = 1'b0;
            end
            n_tests++;
            if ({if8.out_valid, if8.in_ready, if8.cout, if8.sum} !== {1'b1, 1'b0, 1'b0, 8'hFF}) begin
                n_fail++;
                $display("FAIL hold_%0d: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 0 ff",
                         i, if8.out_valid, if8.in_ready, if8.cout, if8.sum);
            end
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        release8();
        n_tests++;
        if ({if8.in_ready, if8.out_valid, if8.sum} !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b sum=%h, want 1 0 ff",
                     if8.in_ready, if8.out_valid, if8.sum);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat; logic [7:0] s; logic c; logic seen;
        if8.a = 8'h33; if8.b = 8'h44; if8.cin = 1'b0; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (if8.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL discarded_op: got out_valid=1 after reset, want 0");
        end
        do_op8(8'h02, 8'h03, 1'b0, lat, s, c);
        n_tests++;
        if ({c, s} !== 9'h005) begin
            n_fail++; $display("FAIL post_reset_sum: got cout=%b sum=%h, want 0 05", c, s);
        end
        release8();
    endtask

    task automatic test_random_w8;
        logic [8:0] q[$];
        logic [8:0] e;
        int acc, res, cyc;
        acc = 0; res = 0; cyc = 0;
        while (acc < 1000 && cyc < 40000) begin
            if8.in_valid  = ($urandom_range(0, 1) == 1);
            if8.a         = 8'($urandom);
            if8.b         = 8'($urandom);
            if8.cin       = 1'($urandom);
            if8.out_ready = ($urandom_range(0, 2) != 0);
            if (if8.in_valid && if8.in_ready) begin
                q.push_back({1'b0, if8.a} + {1'b0, if8.b} + {8'd0, if8.cin});
                acc++;
            end
            if (if8.out_valid && if8.out_ready) begin
                n_tests++; res++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand8_dup: result with no pending operand");
                end else begin
                    e = q.pop_front();
                    if ({if8.cout, if8.sum} !== e) begin
                        n_fail++; $display("FAIL rand8_sum: got %h, want %h", {if8.cout, if8.sum}, e);
                    end
                end
            end
            @(negedge clk); cyc++;
        end
        if8.in_valid = 1'b0; if8.out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (if8.out_valid) begin
                n_tests++; res++;
                e = q.pop_front();
                if ({if8.cout, if8.sum} !== e) begin
                    n_fail++; $display("FAIL rand8_sum: got %h, want %h", {if8.cout, if8.sum}, e);
                end
            end
            @(negedge clk); cyc++;
        end
        if8.out_ready = 1'b0;
        n_tests++;
        if (acc != 1000 || res != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand8_count: got accepted=%0d results=%0d pending=%0d, want 1000 1000 0",
                     acc, res, q.size());
        end
    endtask

    task automatic test_random_w1;
        logic [1:0] q[$];
        logic [1:0] e;
        int acc, res, cyc;
        acc = 0; res = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            if1.in_valid  = ($urandom_range(0, 1) == 1);
            if1.a         = 1'($urandom);
            if1.b         = 1'($urandom);
            if1.cin       = 1'($urandom);
            if1.out_ready = ($urandom_range(0, 2) != 0);
            if (if1.in_valid && if1.in_ready) begin
                q.push_back({1'b0, if1.a} + {1'b0, if1.b} + {1'b0, if1.cin});
                acc++;
            end
            if (if1.out_valid && if1.out_ready) begin
                n_tests++; res++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand1_dup: result with no pending operand");
                end else begin
                    e = q.pop_front();
                    if ({if1.cout, if1.sum} !== e) begin
                        n_fail++; $display("FAIL rand1_sum: got %b, want %b", {if1.cout, if1.sum}, e);
                    end
                end
            end
            @(negedge clk); cyc++;
        end
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            if (if1.out_valid) begin
                n_tests++; res++;
                e = q.pop_front();
                if ({if1.cout, if1.sum} !== e) begin
                    n_fail++; $display("FAIL rand1_sum: got %b, want %b", {if1.cout, if1.sum}, e);
                end
            end
            @(negedge clk); cyc++;
        end
        if1.out_ready = 1'b0;
        n_tests++;
        if (acc != 1000 || res != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand1_count: got accepted=%0d results=%0d pending=%0d, want 1000 1000 0",
                     acc, res, q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random_w8();
        test_random_w1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder with carry-in and carry-out. It is the additive counterpart to the team's subtractor cells. Operands arrive in parallel on a valid/ready handshake and are summed one bit per clock, LSB first, through a single one-bit full-adder cell. The result is then presented on a second valid/ready handshake. It sits in the arithmetic datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  addend A
- b  input  WIDTH  addend B
- cin  input  1  carry-in
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

## Operation
- State machine with three states:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid && in_ready.
  - Load shift_a=a, shift_b=b and carry=cin.
  - Clear bit counter cnt (width $clog2(WIDTH+1)).
  - Clear the sum shift register.
- RUN, each cycle:
  - Compute s = shift_a[0]^shift_b[0]^carry and c = majority(shift_a[0], shift_b[0], carry).
  - Shift shift_a and shift_b right by one.
  - Shift s into sum from the MSB side: sum <= {s, sum[WIDTH-1:1]}.
  - carry <= c; cnt <= cnt+1.
- RUN -> DONE on the cycle where cnt == WIDTH-1, i.e. the last bit is processed. In that same edge, cout <= c.
- DONE -> IDLE on out_ready. sum and cout hold their values until the next acceptance.
- DONE with out_ready=0: hold indefinitely. sum and cout stay stable; in_valid is ignored.
- in_valid while in RUN or DONE: ignored. No operand is captured and no state changes.
- Overflow: no saturation; cout carries the overflow bit.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset may be asserted in any state, including mid-RUN.
  - Immediately returns to IDLE, asynchronously.
  - The in-flight operation is discarded; no out_valid is ever produced for it.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0
  - sum=0, cout=0
  - internal shift_a, shift_b, carry and cnt all 0
- in_ready and out_valid are decoded combinationally from the state register only, with no input-to-output combinational path.
- Latency: acceptance at edge k makes out_valid high after edge k+WIDTH.
- If out_ready is high in that first DONE cycle, the handshake completes at edge k+WIDTH+1 and in_ready is high again after that edge.
- Maximum throughput: one operation per WIDTH+2 cycles. The IDLE cycle is mandatory; there is no back-to-back accept in the DONE->IDLE cycle.
- Intermediate sum bits are not guaranteed meaningful while out_valid=0.

## Structure
- Shared arithmetic package holds:
  - the state typedef enum {IDLE, RUN, DONE}
  - a constant for the default WIDTH
- Sub-module full_adder_cell (inputs a, b, cin; outputs s, cout) is purely combinational and instantiated once.
- serial_adder holds the FSM, the shift registers, the carry flop and the counter.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0:
  - out_valid rises exactly 8 cycles after acceptance.
  - sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: a=8'h5A, b=8'hA5, cin=0, out_ready held low for 5 cycles in DONE.
  - sum=8'hFF, cout=0 stay stable throughout.
  - in_ready stays 0.
  - A pulse of in_valid with a=8'h01 during this window is ignored.
  - Release out_ready -> IDLE one cycle later.
- Reset mid-RUN: accept a=8'h33, b=8'h44, assert rst_n=0 at cycle 3 of RUN.
  - in_ready=1, out_valid=0, sum=0, cout=0 immediately after reset.
  - A subsequent a=8'h02, b=8'h03 yields sum=8'h05.
- Random regression, 1000 operands at WIDTH=8 and at WIDTH=1, with random in_valid/out_ready gaps:
  - every {cout,sum} equals a+b+cin.
  - handshakes are 1:1, with no lost or duplicated result.
